// File: rtl/median_pkg.sv
// Shared encodings for the streaming 3x3 median filter.
// Mode values, FSM states and the window-to-output latency.
package median_pkg;

    localparam logic [1:0] MODE_MED = 2'd0;
    localparam logic [1:0] MODE_MIN = 2'd1;
    localparam logic [1:0] MODE_MAX = 2'd2;
    localparam logic [1:0] MODE_CTR = 2'd3;

    // window register plus three sort stages
    localparam int MED_LAT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/median9_sort.sv
// Pipelined 9-value compare-exchange network with a shared enable.
// Produces min, median and max of the window, plus a passthrough tag.
module median9_sort
    import median_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_vld,
    input  logic [8:0][DATA_W-1:0] i_win,
    input  logic [DATA_W-1:0]      i_tag,
    output logic                   o_vld,
    output logic                   o_busy,
    output logic [DATA_W-1:0]      o_min,
    output logic [DATA_W-1:0]      o_med,
    output logic [DATA_W-1:0]      o_max,
    output logic [DATA_W-1:0]      o_tag
);

    localparam int NS = MED_LAT - 1;

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t mn(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t mx(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t md3(input pix_t a, input pix_t b, input pix_t c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    logic [NS-1:0] r_v;

    pix_t r_lo [3];
    pix_t r_md [3];
    pix_t r_hi [3];
    pix_t r_t1;

    pix_t r_min2;
    pix_t r_max2;
    pix_t r_a;
    pix_t r_b;
    pix_t r_c;
    pix_t r_t2;

    pix_t r_min3;
    pix_t r_med3;
    pix_t r_max3;
    pix_t r_t3;

    // stage 1 sorts each window row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_lo[i] <= '0;
                r_md[i] <= '0;
                r_hi[i] <= '0;
            end
            r_t1 <= '0;
        end else if (i_en) begin
            for (int i = 0; i < 3; i++) begin
                r_lo[i] <= mn(mn(i_win[3*i], i_win[3*i+1]), i_win[3*i+2]);
                r_md[i] <= md3(i_win[3*i], i_win[3*i+1], i_win[3*i+2]);
                r_hi[i] <= mx(mx(i_win[3*i], i_win[3*i+1]), i_win[3*i+2]);
            end
            r_t1 <= i_tag;
        end
    end

    // stage 2 reduces the row columns; the row-min/row-max extremes are global
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min2 <= '0;
            r_max2 <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_t2   <= '0;
        end else if (i_en) begin
            r_min2 <= mn(mn(r_lo[0], r_lo[1]), r_lo[2]);
            r_a    <= mx(mx(r_lo[0], r_lo[1]), r_lo[2]);
            r_b    <= md3(r_md[0], r_md[1], r_md[2]);
            r_c    <= mn(mn(r_hi[0], r_hi[1]), r_hi[2]);
            r_max2 <= mx(mx(r_hi[0], r_hi[1]), r_hi[2]);
            r_t2   <= r_t1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min3 <= '0;
            r_med3 <= '0;
            r_max3 <= '0;
            r_t3   <= '0;
        end else if (i_en) begin
            r_min3 <= r_min2;
            r_med3 <= md3(r_a, r_b, r_c);
            r_max3 <= r_max2;
            r_t3   <= r_t2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else if (i_en) begin
            r_v <= {r_v[NS-2:0], i_vld};
        end
    end

    assign o_vld  = r_v[NS-1];
    assign o_busy = |r_v[NS-2:0];
    assign o_min  = r_min3;
    assign o_med  = r_med3;
    assign o_max  = r_max3;
    assign o_tag  = r_t3;

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter with two line buffers and start/done framing.
// Define MEDIAN_MODE_EN to add the mode port (median/min/max/centre).
module median_filter_stream
    import median_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef MEDIAN_MODE_EN
    input  logic [1:0]        mode,
`endif
    output logic              done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t r_state;
    state_t w_state_nx;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];

    logic [8:0][DATA_W-1:0] r_win;
    logic                   r_win_vld;

    logic [1:0] w_mode;
    logic       w_adv;
    logic       w_acc;
    logic       w_last;
    logic       w_win_done;
    logic       w_busy;
    logic       w_sort_busy;

    logic [DATA_W-1:0] w_top;
    logic [DATA_W-1:0] w_mid;
    logic [DATA_W-1:0] w_min;
    logic [DATA_W-1:0] w_med;
    logic [DATA_W-1:0] w_max;
    logic [DATA_W-1:0] w_ctr;

    assign w_adv      = ~out_valid | out_ready;
    assign in_ready   = (r_state == RUN) & w_adv;
    assign w_acc      = in_valid & in_ready;
    assign w_last     = (r_col == COL_LAST) & (r_row == ROW_LAST);
    assign w_win_done = (r_col >= CW'(2)) & (r_row >= RW'(2));
    assign w_top      = r_lb1[r_col];
    assign w_mid      = r_lb0[r_col];
    assign w_busy     = r_win_vld | w_sort_busy;
    assign done       = (r_state == DONE);

    // counters return to zero after the last pixel, so each frame starts clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else if (w_acc) begin
            r_lb1[r_col] <= w_mid;
            r_lb0[r_col] <= in_data;
        end
    end

    // window columns shift left; a bubble is inserted on idle advancing cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win     <= '0;
            r_win_vld <= 1'b0;
        end else begin
            if (w_adv) begin
                r_win_vld <= w_acc & w_win_done;
            end
            if (w_acc) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_top;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_mid;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (w_acc & w_last) begin
                    w_state_nx = FLUSH;
                end
            end
            FLUSH: begin
                if (~w_busy & out_valid & out_ready) begin
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
        endcase
    end

`ifdef MEDIAN_MODE_EN
    logic [1:0] r_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_MED;
        end else if ((r_state == IDLE) & start) begin
            r_mode <= mode;
        end
    end

    assign w_mode = r_mode;
`else
    assign w_mode = MODE_MED;
`endif

    median9_sort #(
        .DATA_W (DATA_W)
    ) u_sort (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_adv),
        .i_vld  (r_win_vld),
        .i_win  (r_win),
        .i_tag  (r_win[4]),
        .o_vld  (out_valid),
        .o_busy (w_sort_busy),
        .o_min  (w_min),
        .o_med  (w_med),
        .o_max  (w_max),
        .o_tag  (w_ctr)
    );

    always_comb begin
        out_data = w_med;
        case (w_mode)
            MODE_MIN: out_data = w_min;
            MODE_MAX: out_data = w_max;
            MODE_CTR: out_data = w_ctr;
            default:  out_data = w_med;
        endcase
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed bench for median_filter_stream on a 4x4 frame.
// Covers ramp, impulse, backpressure, stray starts, mid-frame reset and modes.
module tb_median_filter_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef MEDIAN_MODE_EN
    logic [1:0] mode;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] pix [16];
    logic [7:0] got [8];
    int         got_n;
    int         done_n;
    int         got_at_done;

    always #5 clk = ~clk;

    median_filter_stream #(
        .DATA_W (8),
        .IMG_W  (4),
        .IMG_H  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef MEDIAN_MODE_EN
        .mode      (mode),
`endif
        .done      (done),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    endtask

    // entered at posedge+1 with the DUT idle
    task automatic run_frame(input string tag, input bit stall, input bit gap,
                             input bit poke, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3);
        int         k = 0;
        int         cyc = 0;
        int         extra = 0;
        bit         stalled = 1'b0;
        bit         poked_run = 1'b0;
        bit         poked_fl = 1'b0;
        logic [7:0] held = 8'h00;
        got_n = 0;
        done_n = 0;
        got_at_done = -1;
        for (int i = 0; i < 8; i++) got[i] = 8'hxx;
        start = 1'b1;
        @(posedge clk); #1;
        while (done_n == 0 && cyc < 400) begin
            in_valid  = (k < 16) && !(gap && $urandom_range(0, 2) == 0);
            in_data   = (k < 16) ? pix[k] : 8'h00;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = 1'b0;
            if (poke && k == 8 && !poked_run) begin
                start = 1'b1;
                poked_run = 1'b1;
            end
            if (poke && k == 16 && !poked_fl) begin
                start = 1'b1;
                poked_fl = 1'b1;
            end
            @(negedge clk);
            if (stalled) begin
                check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_d"}, 32'(out_data), 32'(held));
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                if (got_n < 8) got[got_n] = out_data;
                got_n++;
            end
            if (done) begin
                done_n++;
                got_at_done = got_n;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_n++;
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        check({tag, "_beats"}, 32'(got_n), 32'd4);
        check({tag, "_d0"}, 32'(got[0]), 32'(e0));
        check({tag, "_d1"}, 32'(got[1]), 32'(e1));
        check({tag, "_d2"}, 32'(got[2]), 32'(e2));
        check({tag, "_d3"}, 32'(got[3]), 32'(e3));
        check({tag, "_done_after"}, 32'(got_at_done), 32'd4);
        check({tag, "_done_once"}, 32'(done_n), 32'd1);
        check({tag, "_no_extra"}, 32'(extra), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
`ifdef MEDIAN_MODE_EN
        mode = 2'd0;
`endif
        #12;
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        load_ramp();
        run_frame("ramp", 1'b0, 1'b0, 1'b0, 8'd5, 8'd6, 8'd9, 8'd10);

        for (int i = 0; i < 16; i++) pix[i] = 8'd50;
        pix[6] = 8'd255;
        run_frame("impulse", 1'b0, 1'b0, 1'b0, 8'd50, 8'd50, 8'd50, 8'd50);

        load_ramp();
        run_frame("stall", 1'b1, 1'b1, 1'b0, 8'd5, 8'd6, 8'd9, 8'd10);
        run_frame("poke", 1'b0, 1'b0, 1'b1, 8'd5, 8'd6, 8'd9, 8'd10);
        run_frame("poke_stall", 1'b1, 1'b0, 1'b1, 8'd5, 8'd6, 8'd9, 8'd10);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while (k < 7 && cyc < 50) begin
            in_data = pix[k];
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("mid_beats", 32'(k), 32'd7);
        check("mid_pre_rdy", 32'(in_ready), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(in_ready), 32'd0);
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_od", 32'(out_data), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame("after_rst", 1'b0, 1'b0, 1'b0, 8'd5, 8'd6, 8'd9, 8'd10);

`ifdef MEDIAN_MODE_EN
        mode = 2'd1;
        run_frame("mode_min", 1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 8'd4, 8'd5);
        mode = 2'd2;
        run_frame("mode_max", 1'b1, 1'b0, 1'b0, 8'd10, 8'd11, 8'd14, 8'd15);
        mode = 2'd3;
        run_frame("mode_ctr", 1'b0, 1'b0, 1'b0, 8'd5, 8'd6, 8'd9, 8'd10);
        mode = 2'd0;
        run_frame("mode_med", 1'b0, 1'b1, 1'b0, 8'd5, 8'd6, 8'd9, 8'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
